spi_master_apb: RTL and testbench

Parametrised APB-attached SPI master. It is the next generation of the hard-wired SD-card shifter on the APB2 GPIO bus, generalised to configurable word length, clock divider, SPI mode, bit order and chip-select count. It sits on an external APB slave port of the SoC and drives SD card, flash or display SPI pins directly.

---
 rtl/spi_master_apb.sv | 218 +++++++++++++++++++++
 tb/tb_spi_master_apb.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_apb.sv
// ============================================================================
// Module   : spi_master_apb
// Brief    : APB-attached SPI master; word length, divider, mode, bit order
//            and CS count are configurable. Optional macro SPI_MASTER_IRQ_EN
//            adds the irq output and the CONFIG.IE bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_apb #(
  parameter int DATA_W = 32,
  parameter int NCS    = 1,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        apb_paddr,
  input  logic              apb_psel,
  input  logic              apb_penable,
  input  logic              apb_pwrite,
  input  logic [31:0]       apb_pwdata,
  output logic [31:0]       apb_prdata,
  output logic              apb_pready,
`ifdef SPI_MASTER_IRQ_EN
  output logic              irq,
`endif
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NCS-1:0]    spi_cs_n
);

  localparam int         c_IDX_W = $clog2(DATA_W);
  localparam logic [5:0] c_MAX_N = 6'(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_txdata;
  logic [DATA_W-1:0]   r_rxdata;
  logic                r_cpol;
  logic                r_cpha;
  logic                r_lsb;
  logic [DIV_W-1:0]    r_clkdiv;
  logic [NCS-1:0]      r_cs;
  logic [5:0]          r_nbits;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [6:0]          r_edge;
  logic [5:0]          r_txcnt;
  logic [5:0]          r_rxcnt;
  logic                r_sclk;
  logic                r_mosi;
  logic                r_done;
`ifdef SPI_MASTER_IRQ_EN
  logic                r_ie;
  logic                r_irq;
`endif

  logic        w_access, w_wr, w_busy, w_wr_ok, w_start, w_rx_clr;
  logic        w_tick, w_odd, w_last, w_sample, w_drive, w_tx_bit;
  logic [5:0]  w_start_n, w_first_idx, w_tx_idx, w_rx_idx;
  logic [6:0]  w_edge_nxt;
  logic [31:0] w_config;

  assign w_access    = apb_psel & apb_penable;
  assign w_wr        = w_access & apb_pwrite;
  assign w_busy      = (r_state != ST_IDLE);
  assign w_wr_ok     = w_wr & ~w_busy;
  assign w_start_n   = (apb_pwdata[5:0] > c_MAX_N) ? c_MAX_N : apb_pwdata[5:0];
  assign w_start     = w_wr_ok && (apb_paddr == 8'h0C) && (apb_pwdata[5:0] != 6'd0);
  assign w_rx_clr    = w_access && !apb_pwrite && (apb_paddr == 8'h00);

  // Edge bookkeeping: w_edge_nxt is the 1-based number of the edge about to fire.
  assign w_tick      = (r_div_cnt == '0);
  assign w_edge_nxt  = r_edge + 7'd1;
  assign w_odd       = w_edge_nxt[0];
  assign w_last      = (w_edge_nxt == {r_nbits, 1'b0});
  assign w_sample    = r_cpha ? ~w_odd : w_odd;
  assign w_drive     = r_cpha ? w_odd : (~w_odd & ~w_last);

  assign w_first_idx = r_lsb ? 6'd0 : (w_start_n - 6'd1);
  assign w_tx_idx    = r_lsb ? r_txcnt : (r_nbits - 6'd1 - r_txcnt);
  assign w_rx_idx    = r_lsb ? r_rxcnt : (r_nbits - 6'd1 - r_rxcnt);
  assign w_tx_bit    = r_txdata[w_tx_idx[c_IDX_W-1:0]];

  always_comb begin
    w_config = '0;
    w_config[0] = r_cpol;
    w_config[1] = r_cpha;
    w_config[2] = r_lsb;
`ifdef SPI_MASTER_IRQ_EN
    w_config[3] = r_ie;
`endif
    w_config[8 +: DIV_W] = r_clkdiv;
  end

  always_comb begin
    case (apb_paddr)
      8'h00:   apb_prdata = 32'(r_rxdata);
      8'h04:   apb_prdata = w_config;
      8'h08:   apb_prdata = 32'(r_cs);
      8'h0C:   apb_prdata = {30'd0, r_done, w_busy};
      default: apb_prdata = 32'hFFFF_FFFF;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_txdata  <= '0;
      r_rxdata  <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_lsb     <= 1'b0;
      r_clkdiv  <= '0;
      r_cs      <= '0;
      r_nbits   <= '0;
      r_div_cnt <= '0;
      r_edge    <= '0;
      r_txcnt   <= '0;
      r_rxcnt   <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_done    <= 1'b0;
`ifdef SPI_MASTER_IRQ_EN
      r_ie      <= 1'b0;
      r_irq     <= 1'b0;
`endif
    end else begin
      if (w_wr_ok) begin
        case (apb_paddr)
          8'h00: r_txdata <= apb_pwdata[DATA_W-1:0];
          8'h04: begin
            r_cpol   <= apb_pwdata[0];
            r_cpha   <= apb_pwdata[1];
            r_lsb    <= apb_pwdata[2];
`ifdef SPI_MASTER_IRQ_EN
            r_ie     <= apb_pwdata[3];
`endif
            r_clkdiv <= apb_pwdata[8 +: DIV_W];
          end
          8'h08:   r_cs <= apb_pwdata[NCS-1:0];
          default: ;
        endcase
      end

      // Clear first so that a completion in the same cycle overrides it.
      if (w_rx_clr) r_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_sclk <= r_cpol;
          if (w_start) begin
            r_state   <= ST_SHIFT;
            r_nbits   <= w_start_n;
            r_div_cnt <= r_clkdiv;
            r_edge    <= '0;
            r_rxcnt   <= '0;
            r_rxdata  <= '0;
            r_done    <= 1'b0;
            if (!r_cpha) begin
              r_mosi  <= r_txdata[w_first_idx[c_IDX_W-1:0]];
              r_txcnt <= 6'd1;
            end else begin
              r_txcnt <= 6'd0;
            end
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            r_div_cnt <= r_clkdiv;
            r_sclk    <= ~r_sclk;
            r_edge    <= w_edge_nxt;
            if (w_sample) begin
              r_rxdata[w_rx_idx[c_IDX_W-1:0]] <= spi_miso;
              r_rxcnt <= r_rxcnt + 6'd1;
            end
            if (w_drive) begin
              r_mosi  <= w_tx_bit;
              r_txcnt <= r_txcnt + 6'd1;
            end
            if (w_last) r_state <= ST_HOLD;
          end else begin
            r_div_cnt <= r_div_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_div_cnt <= r_div_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

`ifdef SPI_MASTER_IRQ_EN
      r_irq <= r_done & r_ie;
`endif
    end
  end

  assign apb_pready = 1'b1;
  assign spi_sclk   = r_sclk;
  assign spi_mosi   = r_mosi;
  assign spi_cs_n   = ~r_cs;
`ifdef SPI_MASTER_IRQ_EN
  assign irq        = r_irq;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_master_apb.sv
// ============================================================================
// Module   : tb_spi_master_apb
// Brief    : Self-checking bench for spi_master_apb with an RX scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master_apb;

  localparam int DATA_W = 32;
  localparam int NCS    = 2;
  localparam int DIV_W  = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [7:0]        paddr = '0;
  logic              psel = 1'b0;
  logic              penable = 1'b0;
  logic              pwrite = 1'b0;
  logic [31:0]       pwdata = '0;
  logic [31:0]       prdata;
  logic              pready;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;
  logic [NCS-1:0]    spi_cs_n;
`ifdef SPI_MASTER_IRQ_EN
  logic              irq;
`endif

  logic loop_en  = 1'b0;
  logic miso_val = 1'b0;
  assign spi_miso = loop_en ? spi_mosi : miso_val;

  spi_master_apb #(.DATA_W(DATA_W), .NCS(NCS), .DIV_W(DIV_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .apb_paddr   (paddr),
    .apb_psel    (psel),
    .apb_penable (penable),
    .apb_pwrite  (pwrite),
    .apb_pwdata  (pwdata),
    .apb_prdata  (prdata),
    .apb_pready  (pready),
`ifdef SPI_MASTER_IRQ_EN
    .irq         (irq),
`endif
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_cs_n    (spi_cs_n)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  // Results of the most recent wait_done call.
  int          busy_cyc, rises, nbits;
  bit          timing_ok;
  logic [31:0] mosi_bits;
  logic [31:0] last_status;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int clamp_n(input int n);
    return (n > DATA_W) ? DATA_W : n;
  endfunction

  function automatic logic [31:0] mask_n(input int n);
    logic [31:0] one = 32'h1;
    return (n >= 32) ? 32'hFFFF_FFFF : ((one << n) - 32'h1);
  endfunction

  function automatic logic [31:0] exp_mosi(input logic [31:0] tx, input int n, input bit lsb);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r[i] = lsb ? tx[i] : tx[n-1-i];
    return r;
  endfunction

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk); penable = 1'b1;
    #1 d = prdata;
    @(negedge clk); psel = 1'b0; penable = 1'b0;
  endtask

  // Loads TXDATA, predicts RXDATA into the scoreboard, then issues START.
  task automatic start_xfer(input logic [31:0] tx, input int nreq);
    int nn;
    nn = clamp_n(nreq);
    apb_write(8'h00, tx);
    if (nn == 0)            exp_q.push_back(32'h0);
    else if (loop_en)       exp_q.push_back(tx & mask_n(nn));
    else if (miso_val)      exp_q.push_back(mask_n(nn));
    else                    exp_q.push_back(32'h0);
    apb_write(8'h0C, 32'(nreq));
  endtask

  // Polls STATUS every cycle until busy drops, tracking SCLK edges and the
  // MOSI value present at each sampling edge. Edge k is expected k*d cycles
  // after the START access when called straight after start_xfer.
  task automatic wait_done(input int d, input bit cpha);
    logic p_sclk, p_mosi;
    int   edges, j;
    busy_cyc = 0; rises = 0; nbits = 0; timing_ok = 1'b1; mosi_bits = '0;
    edges = 0; j = 0;
    paddr = 8'h0C; pwrite = 1'b0; psel = 1'b1; penable = 1'b1;
    p_sclk = spi_sclk; p_mosi = spi_mosi;
    #1 last_status = prdata;
    while (last_status[0] && j < 400) begin
      busy_cyc++;
      @(negedge clk); j++;
      if (spi_sclk !== p_sclk) begin
        edges++;
        if (spi_sclk) rises++;
        if (j != edges * d) timing_ok = 1'b0;
        if (cpha ? !edges[0] : edges[0]) begin
          if (nbits < 32) mosi_bits[nbits[4:0]] = p_mosi;
          nbits++;
        end
      end
      p_sclk = spi_sclk; p_mosi = spi_mosi;
      #1 last_status = prdata;
    end
    psel = 1'b0; penable = 1'b0;
    check("xfer_timeout", 32'(last_status[0]), 32'h0);
  endtask

  task automatic pop_rx(input string tag);
    logic [31:0] rx, st;
    apb_read(8'h00, rx);
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'h1, 32'h0);
    else check({tag, "_rx"}, rx, exp_q.pop_front());
    apb_read(8'h0C, st);
    check({tag, "_status_after_rd"}, st, 32'h0);
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] tx, input int nreq,
                          input int d, input bit cpha, input bit lsb);
    int nn;
    nn = clamp_n(nreq);
    start_xfer(tx, nreq);
    wait_done(d, cpha);
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'((2 * nn + 1) * d));
    check({tag, "_rises"}, 32'(rises), 32'(nn));
    check({tag, "_edge_timing"}, 32'(timing_ok), 32'h1);
    if (loop_en) check({tag, "_mosi"}, mosi_bits, exp_mosi(tx, nn, lsb));
    check({tag, "_done"}, last_status, 32'h2);
    pop_rx(tag);
  endtask

  initial begin
    logic [31:0] rd;
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(spi_sclk), 32'h0);
    check("rst_mosi", 32'(spi_mosi), 32'h0);
    check("rst_cs_n", 32'(spi_cs_n), 32'h3);
    check("rst_pready", 32'(pready), 32'h1);
`ifdef SPI_MASTER_IRQ_EN
    check("rst_irq", 32'(irq), 32'h0);
`endif
    reset_n = 1'b1;
    @(negedge clk);
    apb_read(8'h0C, rd); check("rst_status", rd, 32'h0);
    apb_read(8'h04, rd); check("rst_config", rd, 32'h0);
    apb_read(8'h00, rd); check("rst_rxdata", rd, 32'h0);
    apb_read(8'h10, rd); check("unmapped_rd", rd, 32'hFFFF_FFFF);

    // Mode 0, MSB-first, CLKDIV=0, loopback.
    apb_write(8'h08, 32'h1);
    check("cs_n_sel", 32'(spi_cs_n), 32'h2);
    apb_write(8'h04, 32'h0);
    loop_en = 1'b1;
    run_xfer("m0", 32'h0000_00A5, 8, 1, 1'b0, 1'b0);

    // Mode 3, LSB-first, CLKDIV=3, MISO held high.
    apb_write(8'h04, 32'h0000_0307);
    @(negedge clk);
    check("m3_sclk_idle", 32'(spi_sclk), 32'h1);
    loop_en = 1'b0; miso_val = 1'b1;
    start_xfer(32'h1234_5678, 32);
    wait_done(4, 1'b1);
    check("m3_busy_cycles", 32'(busy_cyc), 32'd260);
    check("m3_rises", 32'(rises), 32'd32);
    check("m3_edge_timing", 32'(timing_ok), 32'h1);
    check("m3_mosi", mosi_bits, 32'h1234_5678);
    check("m3_sclk_end", 32'(spi_sclk), 32'h1);
    pop_rx("m3");

    // Length rules.
    apb_write(8'h04, 32'h0);
    loop_en = 1'b1;
    apb_write(8'h0C, 32'h0);
    apb_read(8'h0C, rd); check("n0_ignored", rd, 32'h0);
    run_xfer("n40", 32'hDEAD_BEEF, 40, 1, 1'b0, 1'b0);
    run_xfer("n5", 32'h0000_001F, 5, 1, 1'b0, 1'b0);
    apb_write(8'h04, 32'h0000_0006);
    run_xfer("n5_m1_lsb", 32'hFFFF_FFF3, 5, 1, 1'b1, 1'b1);

    // Writes while busy must be ignored.
    apb_write(8'h04, 32'h0000_0300);
    start_xfer(32'h0000_00C3, 8);
    apb_write(8'h00, 32'h0000_FFFF);
    apb_write(8'h04, 32'h0000_0007);
    apb_write(8'h0C, 32'h0000_0008);
    apb_read(8'h0C, rd); check("prot_status", rd, 32'h1);
    wait_done(4, 1'b0);
    check("prot_done", last_status, 32'h2);
    pop_rx("prot");
    apb_read(8'h04, rd); check("prot_config", rd, 32'h0000_0300);

    // RXDATA read in the completion cycle: the set must win.
    apb_write(8'h04, 32'h0);
    start_xfer(32'h0000_005A, 8);
    paddr = 8'h0C; pwrite = 1'b0; psel = 1'b1; penable = 1'b1;
    repeat (16) @(negedge clk);
    paddr = 8'h00;
    #1;
    if (exp_q.size() == 0) check("coinc_sb_empty", 32'h1, 32'h0);
    else check("coinc_rx", prdata, exp_q.pop_front());
    @(negedge clk);
    paddr = 8'h0C;
    #1 check("coinc_done_kept", prdata, 32'h2);
    psel = 1'b0; penable = 1'b0;
    apb_read(8'h00, rd);
    apb_read(8'h0C, rd); check("coinc_cleared", rd, 32'h0);

`ifdef SPI_MASTER_IRQ_EN
    apb_write(8'h04, 32'h0000_0008);
    start_xfer(32'h0000_0081, 8);
    wait_done(1, 1'b0);
    check("irq_lag", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'h1);
    apb_read(8'h00, rd);
    void'(exp_q.pop_front());
    check("irq_hold", 32'(irq), 32'h1);
    @(negedge clk);
    check("irq_clr", 32'(irq), 32'h0);
    apb_write(8'h04, 32'h0);
`endif

    // Asynchronous reset between edge 5 and edge 6 of a 16-bit transfer.
    apb_write(8'h04, 32'h0000_0100);
    start_xfer(32'h0000_BEEF, 16);
    repeat (11) @(negedge clk);
    check("abort_cs_before", 32'(spi_cs_n), 32'h2);
    reset_n = 1'b0;
    #1;
    check("abort_cs_n", 32'(spi_cs_n), 32'h3);
    check("abort_sclk", 32'(spi_sclk), 32'h0);
    paddr = 8'h0C;
    #1 check("abort_status", prdata, 32'h0);
    paddr = 8'h00;
    #1 check("abort_rxdata", prdata, 32'h0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    apb_write(8'h08, 32'h1);
    run_xfer("post_rst", 32'h0000_003C, 8, 1, 1'b0, 1'b0);

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
